// File: rtl/mem_port_arbiter.sv
// Shares one memory-controller request interface between the instruction-fetch and data ports.
// Optional round-robin tie-break is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
module mem_port_arbiter #(
    parameter int ADDR_W         = 29,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              I_REQ,
    input  logic [ADDR_W-1:0] I_ADDR,
    output logic              I_GNT,
    output logic              I_RVALID,
    output logic [DATA_W-1:0] I_RDATA,
    output logic              I_ERR,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_GNT,
    output logic              D_RVALID,
    output logic              D_WDONE,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ERR,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    output logic              M_READ_REQ,
    output logic              M_WRITE_REQ,
    input  logic              M_READ_READY,
    input  logic              M_WRITE_READY,
    input  logic              M_RVALID,
    input  logic [DATA_W-1:0] M_RDATA,
    output logic              BUSY
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE_RD = 3'd1,
        ISSUE_WR = 3'd2,
        WAIT_RD  = 3'd3,
        RESP     = 3'd4
    } state_t;

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_r;
    logic             owner_d_r;
    logic             drop_r;
    logic [CNT_W-1:0] cnt_r;
    logic             grant_d_s;
    logic             timeout_s;
    logic             rd_ok_s;
    logic             rd_to_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_owner_d_r;

    // Track the most recent grant so ties alternate between ports
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_owner_d_r <= 1'b1;
        end else if (state_r == IDLE && (I_REQ || D_REQ)) begin
            last_owner_d_r <= grant_d_s;
        end else begin
            last_owner_d_r <= last_owner_d_r;
        end
    end
`endif

    // Winner selection and read completion / timeout decode
    always_comb begin
        grant_d_s = 1'b0;
        if (D_REQ && I_REQ) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            grant_d_s = ~last_owner_d_r;
`else
            grant_d_s = 1'b1;
`endif
        end else begin
            grant_d_s = D_REQ;
        end
        timeout_s = (cnt_r == CNT_LAST);
        rd_ok_s   = (state_r == WAIT_RD) && M_RVALID && !drop_r;
        // A read acceptance or genuine data in the last cycle beats the timeout
        rd_to_s   = timeout_s && !rd_ok_s &&
                    (((state_r == ISSUE_RD) && !M_READ_READY) || (state_r == WAIT_RD));
    end

    // Transaction sequencer with registered port and controller outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r     <= IDLE;
            owner_d_r   <= 1'b1;
            drop_r      <= 1'b0;
            cnt_r       <= '0;
            I_GNT       <= 1'b0;
            I_RVALID    <= 1'b0;
            I_RDATA     <= '0;
            I_ERR       <= 1'b0;
            D_GNT       <= 1'b0;
            D_RVALID    <= 1'b0;
            D_WDONE     <= 1'b0;
            D_RDATA     <= '0;
            D_ERR       <= 1'b0;
            M_ADDR      <= '0;
            M_WDATA     <= '0;
            M_READ_REQ  <= 1'b0;
            M_WRITE_REQ <= 1'b0;
            BUSY        <= 1'b0;
        end else begin
            I_GNT    <= 1'b0;
            D_GNT    <= 1'b0;
            I_RVALID <= 1'b0;
            D_RVALID <= 1'b0;
            D_WDONE  <= 1'b0;
            I_ERR    <= 1'b0;
            D_ERR    <= 1'b0;
            // Late data from a timed-out read is swallowed wherever it shows up
            if (drop_r && M_RVALID) begin
                drop_r <= 1'b0;
            end
            case (state_r)
                IDLE: begin
                    if (I_REQ || D_REQ) begin
                        owner_d_r <= grant_d_s;
                        cnt_r     <= '0;
                        BUSY      <= 1'b1;
                        if (grant_d_s) begin
                            M_ADDR  <= D_ADDR;
                            M_WDATA <= D_WDATA;
                            D_GNT   <= 1'b1;
                            if (D_WE) begin
                                state_r     <= ISSUE_WR;
                                M_WRITE_REQ <= 1'b1;
                            end else begin
                                state_r    <= ISSUE_RD;
                                M_READ_REQ <= 1'b1;
                            end
                        end else begin
                            M_ADDR     <= I_ADDR;
                            I_GNT      <= 1'b1;
                            state_r    <= ISSUE_RD;
                            M_READ_REQ <= 1'b1;
                        end
                    end
                end
                ISSUE_RD: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (M_READ_READY) begin
                        state_r    <= WAIT_RD;
                        M_READ_REQ <= 1'b0;
                    end else if (timeout_s) begin
                        state_r    <= RESP;
                        M_READ_REQ <= 1'b0;
                    end
                end
                ISSUE_WR: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (M_WRITE_READY || timeout_s) begin
                        state_r     <= RESP;
                        M_WRITE_REQ <= 1'b0;
                        D_WDONE     <= 1'b1;
                        D_ERR       <= ~M_WRITE_READY;
                    end
                end
                WAIT_RD: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (rd_ok_s || rd_to_s) begin
                        state_r <= RESP;
                    end
                    if (rd_to_s) begin
                        drop_r <= 1'b1;
                    end
                end
                RESP: begin
                    state_r <= IDLE;
                    BUSY    <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    BUSY        <= 1'b0;
                    M_READ_REQ  <= 1'b0;
                    M_WRITE_REQ <= 1'b0;
                end
            endcase
            if (rd_ok_s || rd_to_s) begin
                if (owner_d_r) begin
                    D_RVALID <= 1'b1;
                    D_RDATA  <= rd_ok_s ? M_RDATA : '0;
                    D_ERR    <= rd_to_s;
                end else begin
                    I_RVALID <= 1'b1;
                    I_RDATA  <= rd_ok_s ? M_RDATA : '0;
                    I_ERR    <= rd_to_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed timing checks plus a response/grant scoreboard.
module tb_mem_port_arbiter;

    localparam int AW = 29;
    localparam int DW = 32;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          I_REQ, I_GNT, I_RVALID, I_ERR;
    logic [AW-1:0] I_ADDR;
    logic [DW-1:0] I_RDATA;
    logic          D_REQ, D_WE, D_GNT, D_RVALID, D_WDONE, D_ERR;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA, D_RDATA;
    logic [AW-1:0] M_ADDR;
    logic [DW-1:0] M_WDATA, M_RDATA;
    logic          M_READ_REQ, M_WRITE_REQ, M_READ_READY, M_WRITE_READY, M_RVALID, BUSY;

    typedef struct packed {
        logic          is_d;
        logic          is_wr;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t          sb_q[$];
    logic          gnt_q[$];
    int            check_count = 0;
    int            error_count = 0;
    logic [DW-1:0] last_i = '0;
    logic [DW-1:0] last_d = '0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID),
        .I_RDATA(I_RDATA), .I_ERR(I_ERR),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_WDONE(D_WDONE), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
        .M_ADDR(M_ADDR), .M_WDATA(M_WDATA), .M_READ_REQ(M_READ_REQ), .M_WRITE_REQ(M_WRITE_REQ),
        .M_READ_READY(M_READ_READY), .M_WRITE_READY(M_WRITE_READY),
        .M_RVALID(M_RVALID), .M_RDATA(M_RDATA), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        check_count++;
        if (obs !== expv) begin
            error_count++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [10:0] out_state();
        return {I_GNT, I_RVALID, I_ERR, D_GNT, D_RVALID, D_WDONE, D_ERR,
                M_READ_REQ, M_WRITE_REQ, BUSY, |{I_RDATA, D_RDATA, M_ADDR, M_WDATA}};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_gnt(input string tag);
        int n = 0;
        @(negedge CLK);
        while (!(I_GNT || D_GNT) && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check_eq(tag, 64'(n < 20), 64'd1);
    endtask

    task automatic wait_resp(input string tag);
        int n = 0;
        @(negedge CLK);
        while (!(I_RVALID || D_RVALID || D_WDONE) && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check_eq(tag, 64'(n < 40), 64'd1);
    endtask

    // Monitor: pops grant and response expectations as the DUT produces them
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (I_GNT || D_GNT) begin
                    check_eq("gnt_excl", 64'(I_GNT & D_GNT), 64'd0);
                    check_eq("gnt_expected", 64'(gnt_q.size() != 0), 64'd1);
                    if (gnt_q.size() != 0) check_eq("gnt_port", 64'(D_GNT), 64'(gnt_q.pop_front()));
                end
                if (I_RVALID || D_RVALID || D_WDONE) begin
                    check_eq("resp_excl", 64'(int'(I_RVALID) + int'(D_RVALID) + int'(D_WDONE)), 64'd1);
                    check_eq("resp_expected", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        e = sb_q.pop_front();
                        check_eq("resp_port", 64'(D_RVALID | D_WDONE), 64'(e.is_d));
                        check_eq("resp_kind", 64'(D_WDONE), 64'(e.is_wr));
                        if (e.is_d) begin
                            check_eq("d_err", 64'(D_ERR), 64'(e.err));
                            if (!e.is_wr) begin
                                check_eq("d_rdata", 64'(D_RDATA), 64'(e.data));
                                last_d = e.data;
                            end else begin
                                check_eq("d_rdata_hold_wr", 64'(D_RDATA), 64'(last_d));
                            end
                            check_eq("i_rdata_hold", 64'(I_RDATA), 64'(last_i));
                        end else begin
                            check_eq("i_err", 64'(I_ERR), 64'(e.err));
                            check_eq("i_rdata", 64'(I_RDATA), 64'(e.data));
                            last_i = e.data;
                            check_eq("d_rdata_hold", 64'(D_RDATA), 64'(last_d));
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        I_REQ = 1'b0; I_ADDR = '0; D_REQ = 1'b0; D_WE = 1'b0; D_ADDR = '0; D_WDATA = '0;
        M_READ_READY = 1'b0; M_WRITE_READY = 1'b0; M_RVALID = 1'b0; M_RDATA = '0;
        RST = 1'b1;
        cyc(2);
        check_eq("reset_outputs", 64'(out_state()), 64'd0);
        RST = 1'b0;
        cyc(1);

        // 1: single instruction read, minimum latency
        I_ADDR = 29'h100; I_REQ = 1'b1; M_READ_READY = 1'b1;
        sb_q.push_back('{1'b0, 1'b0, 32'hDEADBEEF, 1'b0}); gnt_q.push_back(1'b0);
        cyc(1);
        check_eq("t1_gnt", 64'(I_GNT), 64'd1);
        check_eq("t1_rdreq", 64'(M_READ_REQ), 64'd1);
        check_eq("t1_addr", 64'(M_ADDR), 64'h100);
        I_REQ = 1'b0;
        cyc(1);
        check_eq("t1_wait_rdreq", 64'(M_READ_REQ), 64'd0);
        M_RVALID = 1'b1; M_RDATA = 32'hDEADBEEF;
        cyc(1);
        check_eq("t1_rvalid", 64'(I_RVALID), 64'd1);
        check_eq("t1_rdata", 64'(I_RDATA), 64'hDEADBEEF);
        M_RVALID = 1'b0; M_READ_READY = 1'b0;
        cyc(1);
        check_eq("t1_idle", 64'(BUSY), 64'd0);

        // 2: data write with controller not ready for three cycles
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 29'h20; D_WDATA = 32'h12345678;
        sb_q.push_back('{1'b1, 1'b1, 32'h0, 1'b0}); gnt_q.push_back(1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc(1);
            check_eq("t2_wrreq", 64'(M_WRITE_REQ), 64'd1);
            check_eq("t2_m_addr_wdata", {35'(M_ADDR), M_WDATA[28:0]}, {35'h20, 29'(32'h12345678)});
            check_eq("t2_no_wdone", 64'(D_WDONE), 64'd0);
            if (k == 1) begin
                check_eq("t2_gnt", 64'(D_GNT), 64'd1);
                D_REQ = 1'b0;
            end
            if (k == 4) M_WRITE_READY = 1'b1;
        end
        cyc(1);
        check_eq("t2_wdone", 64'(D_WDONE), 64'd1);
        check_eq("t2_err", 64'(D_ERR), 64'd0);
        check_eq("t2_wrreq_drop", 64'(M_WRITE_REQ), 64'd0);
        M_WRITE_READY = 1'b0; D_WE = 1'b0;
        cyc(1);
        check_eq("t2_idle", 64'(BUSY), 64'd0);

        // 3: both ports held requesting, four grants
        M_READ_READY = 1'b1; M_RVALID = 1'b1; I_ADDR = 29'h300; D_ADDR = 29'h400;
        I_REQ = 1'b1; D_REQ = 1'b1;
        for (int g = 0; g < 4; g++) begin
            logic exp_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            exp_d = (g % 2) == 1;
`else
            exp_d = 1'b1;
`endif
            M_RDATA = 32'hC0DE0000 + 32'(g);
            sb_q.push_back('{exp_d, 1'b0, 32'hC0DE0000 + 32'(g), 1'b0}); gnt_q.push_back(exp_d);
            wait_gnt("t3_gnt_wait");
            if (D_GNT) D_REQ = 1'b0;
            else I_REQ = 1'b0;
            wait_resp("t3_resp_wait");
            if (g < 3) begin
                I_REQ = 1'b1; D_REQ = 1'b1;
            end else begin
                I_REQ = 1'b0; D_REQ = 1'b0;
            end
        end
        M_RVALID = 1'b0;
        cyc(1);

        // 4: read timeout, then a stale response must be discarded
        begin
            int early = 0;
            D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 29'h40;
            sb_q.push_back('{1'b1, 1'b0, 32'h0, 1'b1}); gnt_q.push_back(1'b1);
            cyc(1);
            check_eq("t4_gnt", 64'(D_GNT), 64'd1);
            D_REQ = 1'b0;
            for (int k = 2; k <= TO; k++) begin
                cyc(1);
                early += int'(D_RVALID);
            end
            check_eq("t4_no_early_rvalid", 64'(early), 64'd0);
            cyc(1);
            check_eq("t4_to_rvalid", 64'(D_RVALID), 64'd1);
            check_eq("t4_to_err", 64'(D_ERR), 64'd1);
            check_eq("t4_to_rdata", 64'(D_RDATA), 64'd0);
        end
        cyc(1);
        I_REQ = 1'b1; I_ADDR = 29'h200;
        sb_q.push_back('{1'b0, 1'b0, 32'h5A5A1234, 1'b0}); gnt_q.push_back(1'b0);
        cyc(1);
        check_eq("t4_i_gnt", 64'(I_GNT), 64'd1);
        I_REQ = 1'b0;
        cyc(1);
        M_RVALID = 1'b1; M_RDATA = 32'hAAAA5555;
        cyc(1);
        check_eq("t4_stale_dropped", 64'(I_RVALID), 64'd0);
        check_eq("t4_still_busy", 64'(BUSY), 64'd1);
        M_RDATA = 32'h5A5A1234;
        cyc(1);
        check_eq("t4_i_rvalid", 64'(I_RVALID), 64'd1);
        check_eq("t4_i_rdata", 64'(I_RDATA), 64'h5A5A1234);
        M_RVALID = 1'b0;
        cyc(1);

        // 5: reset in WAIT_RD aborts the read with no response
        D_REQ = 1'b1; D_WE = 1'b0; D_ADDR = 29'h60; gnt_q.push_back(1'b1);
        cyc(1);
        check_eq("t5_gnt", 64'(D_GNT), 64'd1);
        D_REQ = 1'b0;
        cyc(1);
        check_eq("t5_busy", 64'(BUSY), 64'd1);
        #2 RST = 1'b1;
        #1 check_eq("t5_reset_now", 64'(out_state()), 64'd0);
        cyc(1);
        RST = 1'b0; last_i = '0; last_d = '0;
        M_RVALID = 1'b1; M_RDATA = 32'hBAD0BAD0;
        cyc(1);
        M_RVALID = 1'b0;
        cyc(3);
        check_eq("t5_quiet", 64'(out_state()), 64'd0);
        I_REQ = 1'b1; I_ADDR = 29'h300;
        sb_q.push_back('{1'b0, 1'b0, 32'h0BADF00D, 1'b0}); gnt_q.push_back(1'b0);
        cyc(1);
        check_eq("t5_i_gnt", 64'(I_GNT), 64'd1);
        I_REQ = 1'b0;
        cyc(1);
        M_RVALID = 1'b1; M_RDATA = 32'h0BADF00D;
        cyc(1);
        check_eq("t5_i_rvalid", 64'(I_RVALID), 64'd1);
        M_RVALID = 1'b0;
        cyc(1);

        // 6: request re-raised during RESP is granted only after IDLE
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 29'h70; D_WDATA = 32'hA1; M_WRITE_READY = 1'b1;
        sb_q.push_back('{1'b1, 1'b1, 32'h0, 1'b0}); gnt_q.push_back(1'b1);
        cyc(1);
        check_eq("t6_gnt1", 64'(D_GNT), 64'd1);
        D_REQ = 1'b0;
        cyc(1);
        check_eq("t6_wdone1", 64'(D_WDONE), 64'd1);
        D_REQ = 1'b1; D_ADDR = 29'h74; D_WDATA = 32'hA2;
        sb_q.push_back('{1'b1, 1'b1, 32'h0, 1'b0}); gnt_q.push_back(1'b1);
        cyc(1);
        check_eq("t6_no_gnt_in_idle", 64'(D_GNT), 64'd0);
        check_eq("t6_idle", 64'(BUSY), 64'd0);
        cyc(1);
        check_eq("t6_gnt2", 64'(D_GNT), 64'd1);
        check_eq("t6_addr2", 64'(M_ADDR), 64'h74);
        D_REQ = 1'b0;
        cyc(1);
        check_eq("t6_wdone2", 64'(D_WDONE), 64'd1);
        cyc(2);
        check_eq("t6_no_dup", 64'(BUSY), 64'd0);
        M_WRITE_READY = 1'b0;

        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        check_eq("gnt_drained", 64'(gnt_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
